// File: rtl/imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder.
// Holds the CPU address width, FSM state encodings and the default base address.
// Also provides the fetch address range/alignment check used by the responder.
package imem_resp_pkg;

  localparam int CPU_WIDTH = 32;
  localparam logic [CPU_WIDTH-1:0] IMEM_BASE_ADDR = 32'h8000_0000;

  // Wide enough for LATENCY-1 (max 14) plus the optional random extra delay (max 3)
  localparam int IMEM_CNT_W = 5;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

  // True when the byte address is misaligned or falls outside [base, base+span)
  function automatic logic imem_addr_err(input logic [CPU_WIDTH-1:0] addr,
                                         input logic [CPU_WIDTH-1:0] base,
                                         input logic [CPU_WIDTH:0]   span_bytes);
    logic [CPU_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] != 2'b00) || off[CPU_WIDTH] || (off >= span_bytes);
  endfunction

endpackage

// File: rtl/imem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset, advancing every cycle.
// Latency: new value every clock; no backpressure.
// Only compiled when IMEM_RAND_DELAY_EN is defined, as it has no user otherwise.
`ifdef IMEM_RAND_DELAY_EN
module imem_lfsr (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_rand
);

  logic [7:0] lfsr_q, lfsr_d;

  // Shift left, feeding back the XOR of taps 8,6,5,4
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State register with seed on reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign o_rand = lfsr_q;

endmodule
`endif

// File: rtl/imem_resp.sv
// Instruction-memory responder: word-addressed instruction array behind a fetch valid/ready handshake.
// Latency: LATENCY cycles from accept to o_inst_valid (+0..3 random cycles with IMEM_RAND_DELAY_EN).
// Backpressure: one request in flight; o_req_ready low until the response is taken by i_inst_ready.
module imem_resp
  import imem_resp_pkg::*;
#(
  parameter int                   DEPTH     = 4096,
  parameter int                   LATENCY   = 1,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR = IMEM_BASE_ADDR,
  localparam int                  IDX_W     = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mem_rden,
  input  logic [CPU_WIDTH-1:0] i_mem_addr,
  output logic                 o_req_ready,
  output logic [31:0]          o_inst,
  output logic                 o_inst_valid,
  output logic                 o_inst_err,
  input  logic                 i_inst_ready,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [31:0]          i_wr_data
);

  localparam logic [CPU_WIDTH:0]    SPAN_BYTES = (CPU_WIDTH+1)'(DEPTH) << 2;
  localparam logic [IMEM_CNT_W-1:0] CNT_BASE   = IMEM_CNT_W'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  imem_state_e           state_q, state_d;
  logic [CPU_WIDTH-1:0]  addr_q, addr_d;
  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           inst_q, inst_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  inst_valid_q, inst_valid_d;

  logic [1:0]            extra_dly;
  logic                  rd_err;
  logic [IDX_W-1:0]      rd_idx;

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_rand;
  logic       unused_rand;

  imem_lfsr u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_rand (lfsr_rand)
  );

  assign extra_dly   = lfsr_rand[1:0];
  assign unused_rand = ^lfsr_rand[7:2];
`else
  assign extra_dly = 2'd0;
`endif

  // Decode the latched fetch address into an error flag and a word index
  assign rd_err = imem_addr_err(addr_q, BASE_ADDR, SPAN_BYTES);
  assign rd_idx = IDX_W'((addr_q - BASE_ADDR) >> 2);

  // Preload port; old contents are seen by a read on the same edge
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_idx] <= i_wr_data;
  end

  // Next-state and datapath for the accept / wait / respond sequence
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      IMEM_IDLE: begin
        if (i_mem_rden) begin
          addr_d  = i_mem_addr;
          cnt_d   = CNT_BASE + IMEM_CNT_W'(extra_dly);
          state_d = IMEM_WAIT;
        end
      end
      IMEM_WAIT: begin
        if (cnt_q == '0) begin
          inst_d  = rd_err ? 32'h0 : mem[rd_idx];
          err_d   = rd_err;
          state_d = IMEM_RESP;
        end else begin
          cnt_d = cnt_q - IMEM_CNT_W'(1);
        end
      end
      IMEM_RESP: begin
        if (i_inst_ready) state_d = IMEM_IDLE;
      end
      default: state_d = IMEM_IDLE;
    endcase
    req_ready_d  = (state_d == IMEM_IDLE);
    inst_valid_d = (state_d == IMEM_RESP);
  end

  // FSM state and registered outputs; reset drops any in-flight request
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IMEM_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      inst_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_inst_err   = err_q;

endmodule

// File: tb/tb_imem_resp.sv
// Testbench for imem_resp: two instances (LATENCY 1 and 3) driven by directed fetches.
// Expected responses are queued at issue time; a negedge monitor pops and compares.
// Also checks response latency, stability under stall, and the return to ready after handshake.
module tb_imem_resp;
  import imem_resp_pkg::*;

  localparam int DEPTH = 4096;
  localparam int IW    = 12;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n      [2];
  logic          rden       [2];
  logic [31:0]   addr       [2];
  logic          req_ready  [2];
  logic [31:0]   inst       [2];
  logic          inst_valid [2];
  logic          inst_err   [2];
  logic          inst_ready [2];
  logic          wr_en      [2];
  logic [IW-1:0] wr_idx     [2];
  logic [31:0]   wr_data    [2];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int   lat_n   [2] = '{1, 3};
  int   acc_cyc [2];
  bit   in_resp [2];
  bit   exp_idle[2];
  exp_t held    [2];

  imem_resp #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n[0]), .i_mem_rden(rden[0]), .i_mem_addr(addr[0]),
    .o_req_ready(req_ready[0]), .o_inst(inst[0]), .o_inst_valid(inst_valid[0]),
    .o_inst_err(inst_err[0]), .i_inst_ready(inst_ready[0]), .i_wr_en(wr_en[0]),
    .i_wr_idx(wr_idx[0]), .i_wr_data(wr_data[0])
  );

  imem_resp #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(32'h8000_0000)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n[1]), .i_mem_rden(rden[1]), .i_mem_addr(addr[1]),
    .o_req_ready(req_ready[1]), .o_inst(inst[1]), .o_inst_valid(inst_valid[1]),
    .o_inst_err(inst_err[1]), .i_inst_ready(inst_ready[1]), .i_wr_en(wr_en[1]),
    .i_wr_idx(wr_idx[1]), .i_wr_data(wr_data[1])
  );

  function automatic exp_t mk(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    return e;
  endfunction

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %h required %h", name, d, act, expv);
    end
  endtask

  // Monitor: compare each new response with the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        in_resp[d]  = 1'b0;
        exp_idle[d] = 1'b0;
      end else begin
        if (exp_idle[d]) begin
          check(d, "ready_after_hs", 32'(req_ready[d]), 32'd1);
          check(d, "valid_after_hs", 32'(inst_valid[d]), 32'd0);
          exp_idle[d] = 1'b0;
        end
        if (inst_valid[d]) begin
          if (!in_resp[d]) begin
            in_resp[d] = 1'b1;
            held[d]    = mk(inst[d], inst_err[d]);
            if (qsz(d) == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp dut%0d: got inst=%h err=%b, required no response", d, inst[d], inst_err[d]);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              check(d, "resp_data", inst[d], e.data);
              check(d, "resp_err", 32'(inst_err[d]), 32'(e.err));
              lat = cyc - acc_cyc[d];
`ifdef IMEM_RAND_DELAY_EN
              checks++;
              if (lat < lat_n[d] || lat > lat_n[d] + 3) begin
                errors++;
                $display("FAIL latency dut%0d: got %0d required %0d..%0d", d, lat, lat_n[d], lat_n[d] + 3);
              end
`else
              check(d, "latency", 32'(lat), 32'(lat_n[d]));
`endif
            end
          end else begin
            check(d, "stall_data", inst[d], held[d].data);
            check(d, "stall_err", 32'(inst_err[d]), 32'(held[d].err));
          end
          if (inst_ready[d]) begin
            in_resp[d]  = 1'b0;
            exp_idle[d] = 1'b1;
          end
        end
        if (rden[d] && req_ready[d]) acc_cyc[d] = cyc + 1;
      end
    end
  end

  task automatic preload(input int d, input int idx, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en[d]   = 1'b1;
    wr_idx[d]  = IW'(idx);
    wr_data[d] = data;
    @(posedge clk); #1;
    wr_en[d] = 1'b0;
  endtask

  // Returns just after the edge at which the pending request is accepted
  task automatic wait_accept(input int d);
    int n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready got 0 required 1", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int d, input logic [31:0] a, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    rden[d] = 1'b1;
    addr[d] = a;
    wait_accept(d);
    rden[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    @(negedge clk); #2;
    while ((qsz(d) != 0 || in_resp[d] || !req_ready[d]) && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check(d, "drain_left", 32'(qsz(d)), 32'd0);
  endtask

  task automatic wait_valid(input int d);
    int n = 0;
    @(negedge clk);
    while (!inst_valid[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(d, "valid_seen", 32'(inst_valid[d]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nloop;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; rden[d] = 1'b0; addr[d] = '0; inst_ready[d] = 1'b1;
      wr_en[d] = 1'b0; wr_idx[d] = '0; wr_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(d, "rst_req_ready", 32'(req_ready[d]), 32'd1);
      check(d, "rst_inst_valid", 32'(inst_valid[d]), 32'd0);
      check(d, "rst_inst", inst[d], 32'h0);
      check(d, "rst_inst_err", 32'(inst_err[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Basic fetch, LATENCY 1
    preload(0, 0, 32'h0000_0413);
    fetch(0, 32'h8000_0000, mk(32'h0000_0413, 1'b0));
    drain(0);

    // LATENCY 3 with consumer stall
    preload(1, 2, 32'hDEAD_BEEF);
    inst_ready[1] = 1'b0;
    fetch(1, 32'h8000_0008, mk(32'hDEAD_BEEF, 1'b0));
    wait_valid(1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    inst_ready[1] = 1'b1;
    drain(1);

    // Misaligned, below base, one past the end, and the last valid word
    preload(0, 4095, 32'hCAFE_F00D);
    fetch(0, 32'h8000_0002, mk(32'h0, 1'b1));      drain(0);
    fetch(0, 32'h7FFF_FFFC, mk(32'h0, 1'b1));      drain(0);
    fetch(0, 32'h8000_4000, mk(32'h0, 1'b1));      drain(0);
    fetch(0, 32'h8000_3FFC, mk(32'hCAFE_F00D, 1'b0)); drain(0);

    // Request held during WAIT with a changed address: second is serviced only after the first
    preload(1, 3, 32'h1111_1111);
    preload(1, 4, 32'h2222_2222);
    q1.push_back(mk(32'h1111_1111, 1'b0));
    q1.push_back(mk(32'h2222_2222, 1'b0));
    @(posedge clk); #1;
    rden[1] = 1'b1;
    addr[1] = 32'h8000_000C;
    wait_accept(1);
    addr[1] = 32'h8000_0010;
    wait_accept(1);
    rden[1] = 1'b0;
    drain(1);

    // Write on the same edge as the array read returns the old word
    preload(0, 1, 32'h0);
`ifndef IMEM_RAND_DELAY_EN
    fetch(0, 32'h8000_0004, mk(32'h0, 1'b0));
    wr_en[0]   = 1'b1;
    wr_idx[0]  = IW'(1);
    wr_data[0] = 32'h1234_5678;
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    drain(0);
`else
    preload(0, 1, 32'h1234_5678);
`endif
    fetch(0, 32'h8000_0004, mk(32'h1234_5678, 1'b0));
    drain(0);

    // Reset during WAIT drops the request and keeps the array
    preload(1, 5, 32'h55AA_55AA);
    @(posedge clk); #1;
    rden[1] = 1'b1;
    addr[1] = 32'h8000_0014;
    wait_accept(1);
    rden[1] = 1'b0;
    #2;
    rst_n[1] = 1'b0;
    #1;
    check(1, "midrst_req_ready", 32'(req_ready[1]), 32'd1);
    check(1, "midrst_inst_valid", 32'(inst_valid[1]), 32'd0);
    check(1, "midrst_inst", inst[1], 32'h0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    repeat (6) @(negedge clk);
    check(1, "postrst_inst_valid", 32'(inst_valid[1]), 32'd0);
    check(1, "postrst_req_ready", 32'(req_ready[1]), 32'd1);
    fetch(1, 32'h8000_0014, mk(32'h55AA_55AA, 1'b0)); drain(1);
    fetch(1, 32'h8000_0008, mk(32'hDEAD_BEEF, 1'b0)); drain(1);

    // Repeated fetches; latency is checked by the monitor for each
`ifdef IMEM_RAND_DELAY_EN
    nloop = 100;
`else
    nloop = 8;
`endif
    for (int i = 0; i < nloop; i++) begin
      fetch(0, 32'h8000_0000, mk(32'h0000_0413, 1'b0));
      drain(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
# imem_resp

Instruction-memory responder on the fetch interface: accepts the PC and read-enable issued by the IFU, looks up a word-addressed instruction array after a configurable latency, and returns the instruction with a valid/ready handshake. It sits between the IFU and the decode stage and stands in for the instruction SRAM during simulation and bring-up. A side write port preloads the array.

## Interface
- `DEPTH`, default 4096: number of 32-bit words in the array; power of two.
- `LATENCY`, default 1: base cycles from request acceptance to response; legal range 1..15.
- `BASE_ADDR`, default 32'h80000000: byte address of word 0.
- `i_clk`  input  1: clock, rising edge.
- `i_rst`  input  1: asynchronous, active-low reset.
- `i_mem_rden`  input  1: fetch request valid.
- `i_mem_addr`  input  `CPU_WIDTH`: fetch byte address (PC).
- `o_req_ready`  output  1: responder can accept a request.
- `o_inst`  output  32: returned instruction.
- `o_inst_valid`  output  1: `o_inst`/`o_inst_err` are valid.
- `o_inst_err`  output  1: request was misaligned or out of range.
- `i_inst_ready`  input  1: consumer accepts the response.
- `i_wr_en`  input  1: preload write strobe.
- `i_wr_idx`  input  log2(DEPTH): preload word index.
- `i_wr_data`  input  32: preload data.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `o_req_ready`=1. When `i_mem_rden`=1, accept: latch address, load counter with LATENCY-1 (+ extra delay, see Configuration), go to WAIT.
- WAIT: `o_req_ready`=0. If counter==0, read the array, register `o_inst`/`o_inst_err`, go to RESP; otherwise decrement.
- RESP: `o_inst_valid`=1, outputs held stable. If `i_inst_ready`=1, go to IDLE.
- While not in IDLE, `i_mem_rden` is ignored; the request is not queued. The IFU holds `i_mem_rden` until it sees `o_req_ready`.
- Word index = (addr - BASE_ADDR) >> 2.
- Error when addr[1:0]!=0, addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH. On error: `o_inst`=0 and `o_inst_err`=1, and the array is not read.
- Preload write takes effect at the clock edge regardless of FSM state.
- A same-cycle write and array read to the same index returns the old data (read-before-write).
- The array is not reset; its contents survive `i_rst`.

## Timing
- Reset values: state IDLE, `o_req_ready`=1, `o_inst`=0, `o_inst_valid`=0, `o_inst_err`=0, counter 0.
- `o_req_ready` and `o_inst_valid` are decoded from registered state only; there is no combinational path from inputs.
- Accept at edge N means `o_inst_valid`=1 from edge N+LATENCY (+extra delay).
- Response held until the edge where `i_inst_ready`=1. `o_req_ready` rises the cycle after that edge, so there is at most one request per LATENCY+1 cycles.
- Reset asserted mid-request (WAIT or RESP): the request is dropped, outputs return to reset values immediately, and no response is produced.

## Configuration
- `IMEM_RAND_DELAY_EN` defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle. At acceptance, lfsr[1:0] (0..3) is added to the loaded counter value.
- `IMEM_RAND_DELAY_EN` undefined: no LFSR; latency is exactly LATENCY.

## Structure
- Shared defines: `CPU_WIDTH`, the IMEM_IDLE/WAIT/RESP encodings (2 bits), the default `BASE_ADDR`.
- Sub-module `imem_lfsr` (8-bit LFSR, `i_clk`/`i_rst`, output `o_rand[7:0]`). It is instantiated only under `IMEM_RAND_DELAY_EN`.
- Array is a plain reg memory, one write port and one registered read.

## Test plan
- Reset, then preload idx 0 = 32'h00000413, LATENCY=1, request 0x80000000 with `i_inst_ready`=1 → `o_inst_valid` one cycle after accept, `o_inst`=32'h00000413, err=0, `o_req_ready` back to 1 next cycle.
- LATENCY=3, request 0x80000008 (idx 2 = 32'hDEADBEEF), `i_inst_ready` held 0 for 4 cycles → valid 3 cycles after accept, data stable across the stall, IDLE the cycle after ready.
- Requests 0x80000002 and 0x7FFFFFFC → `o_inst`=0, `o_inst_err`=1 for each.
- `i_mem_rden` held high during WAIT with a changing address → only the first address is serviced; the second is accepted only after the response handshake.
- Write idx 1 = 32'h12345678 on the same edge the array reads idx 1 (old value 32'h0) → response 32'h0; a following read returns 32'h12345678.
- `i_rst` low during WAIT → `o_inst_valid` never asserts, state IDLE, array contents preserved. With `IMEM_RAND_DELAY_EN` defined: latency stays within LATENCY..LATENCY+3 over 100 requests.
